keycode_avmm_slave: RTL and testbench
=====================================

Name: keycode_avmm_slave

Overview:
- Avalon-MM responder on the SoC bus. The NIOS USB-keyboard driver writes keycodes into it.
- Keycodes are buffered in a small FIFO and released to game logic (jumplogic, color_mapper) once per video frame, in sync with the frame clock.
- It also returns game status to the CPU through read-only registers: score, FSM state and airtime.
- It replaces the plain keycode PIO with a buffered, frame-synchronous path that can be read back.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- KW, 8, keycode width.

Ports:
- Clk  in  1  50 MHz system clock (MAX10_CLK1_50); same domain as vga_controller.
- Reset_n  in  1  asynchronous active-low reset.
- avs_address  in  2  word register index.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed latency 1.
- frame_clk  in  1  VGA_VS, synchronous to Clk.
- score  in  16  game score.
- outstate  in  6  jumplogic FSM state.
- airtime  in  8  jumplogic airtime.
- keycode  out  8  keycode released for the current frame.
- key_valid  out  1  high for 1 Clk cycle when keycode updates.
- fifo_level  out  4  entry count, for LEDR debug.

Behaviour:
- Reset: all FIFO pointers 0; level 0; overflow 0; enable 1; keycode 8'h00; key_valid 0; avs_readdata 0.
- Register map:
  - 0 DATA: write pushes writedata[7:0]. Read returns {24'b0, head entry}, or 0 when empty; the read does not pop.
  - 1 STATUS: read {21'b0, overflow[10], full[9], empty[8], 4'b0, level[3:0]}. Writing 1 to bit 10 clears overflow.
  - 2 GAME: read {airtime[31:24], 2'b0, outstate[21:16], score[15:0]}. Writes ignored.
  - 3 CTRL: read/write. Bit 0 enable (reset 1). Bit 1 flush: self-clearing, always reads 0.
- Read latency: avs_readdata is registered. Data is valid exactly 1 cycle after avs_read. No waitrequest. avs_readdata holds its value when there is no read.
- Simultaneous avs_read and avs_write in one cycle: the write takes effect; readdata is undefined and the bench must not check it.
- Frame tick:
  - frame_clk is registered once; tick = current & ~previous.
  - The tick is active one cycle after the rising edge is sampled.
- On tick with enable=1 and FIFO not empty:
  - pop the head into keycode;
  - key_valid=1 for that one cycle.
- On tick with FIFO empty:
  - keycode holds its previous value (the driver pushes 8'h00 on key release);
  - key_valid stays 0.
- enable=0: ticks are ignored; pushes are still accepted.
- Push when full with no pop in the same cycle:
  - data is dropped;
  - overflow is set (sticky);
  - level is unchanged.
- Push and pop in the same cycle:
  - when full: both happen, no overflow, level unchanged;
  - when empty: only the push happens, and the entry waits for the next tick.
- Flush:
  - pointers and level go to 0 in the cycle after the write;
  - keycode and overflow are unchanged;
  - a push in the same cycle as the flush write is discarded.
- Pointer widths: log2(DEPTH) bits, wrap naturally. Level is a separate counter, 0..DEPTH.
- Asserting Reset_n low mid-transfer aborts the transfer. State returns to reset values immediately; no partial pop.

Optional Feature:
- Macro KEY_DEDUP_EN.
- Defined: a push whose keycode equals the last accepted push is discarded. This covers the driver re-sending the same keycode every USB poll. The discarded push does not set overflow. The last-accepted register resets to 8'hFF.
- Undefined: every push is accepted.

Decomposition:
- Package keycode_avmm_pkg holds:
  - register address localparams ADDR_DATA=0, ADDR_STATUS=1, ADDR_GAME=2, ADDR_CTRL=3;
  - STATUS/CTRL bit-position constants;
  - a status_t packed struct.
- One sub-module, keycode_fifo: a synchronous FIFO with push, pop, flush, full, empty and level outputs.
- Register decode and frame-tick logic stay in the top module.

Test Plan:
- Reset, then read STATUS -> readdata = 32'h0000_0100 one cycle later; keycode=0, key_valid=0.
- Write 8'h1A, 8'h04 to DATA, then one frame_clk rise -> keycode=8'h1A with a one-cycle key_valid; level=1. Next rise -> keycode=8'h04, level=0. Third rise -> keycode stays 8'h04, no key_valid.
- 9 pushes with DEPTH=8 and no ticks -> STATUS=32'h0000_0608, meaning overflow=1, full=1, level=8. The first 8 values pop in order. Writing 32'h400 to STATUS -> overflow=0.
- Fill FIFO, then push in the exact cycle of a tick -> no overflow, level stays 8, pushed value becomes the tail.
- score=16'h0123, outstate=6'h05, airtime=8'h3C, read GAME -> 32'h3C05_0123. Write CTRL=2 with 3 entries queued -> level=0, keycode unchanged.
- KEY_DEDUP_EN defined: push 8'h07 three times, then 8'h00 -> level=2, overflow=0. Undefined: the same stimulus -> level=4.

Source files
------------

// File: rtl/keycode_avmm_pkg.sv
// Shared register map, bit positions and STATUS layout for the keycode Avalon-MM slave.
package keycode_avmm_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_GAME   = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int STAT_OVF_BIT   = 10;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_EMPTY_BIT = 8;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  // Wide enough for level 0..16 (largest supported DEPTH)
  localparam int LVL_W = 5;

  typedef struct packed {
    logic [20:0] rsvd_hi;
    logic        overflow;
    logic        full;
    logic        empty;
    logic [3:0]  rsvd_lo;
    logic [3:0]  level;
  } status_t;

endpackage

// File: rtl/keycode_fifo.sv
// Synchronous keycode FIFO with separate level counter; flush has priority over push and pop.
module keycode_fifo
  import keycode_avmm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [KW-1:0]    din,
  output logic [KW-1:0]    head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             push_done,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [KW-1:0]    mem_q [DEPTH];
  logic [KW-1:0]    mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO survives it
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & ~flush & (~full | do_pop);
  assign push_done = do_push;
  assign push_drop = push & ~flush & full & ~do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/keycode_avmm_slave.sv
// Avalon-MM keycode buffer released once per video frame, plus read-only game status.
// Define KEY_DEDUP_EN to drop pushes that repeat the last accepted keycode.
module keycode_avmm_slave
  import keycode_avmm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KW    = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [1:0]    avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [31:0]   avs_writedata,
  output logic [31:0]   avs_readdata,
  input  logic          frame_clk,
  input  logic [15:0]   score,
  input  logic [5:0]    outstate,
  input  logic [7:0]    airtime,
  output logic [KW-1:0] keycode,
  output logic          key_valid,
  output logic [3:0]    fifo_level
);

  logic             frame_cur_q, frame_prev_q;
  logic             enable_q, enable_d;
  logic             overflow_q, overflow_d;
  logic [KW-1:0]    keycode_q, keycode_d;
  logic             key_valid_q, key_valid_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_data, wr_status, wr_ctrl;
  logic             push_req, flush, tick, pop_fire;
  logic [KW-1:0]    fifo_head;
  logic             fifo_full, fifo_empty, push_done, push_drop;
  logic [LVL_W-1:0] fifo_lvl;
  status_t          status;
  logic             unused_bits;

  assign wr_data   = avs_write & (avs_address == ADDR_DATA);
  assign wr_status = avs_write & (avs_address == ADDR_STATUS);
  assign wr_ctrl   = avs_write & (avs_address == ADDR_CTRL);
  assign flush     = wr_ctrl & avs_writedata[CTRL_FLUSH_BIT];

`ifdef KEY_DEDUP_EN
  logic [KW-1:0] last_q, last_d;

  assign push_req = wr_data & (avs_writedata[KW-1:0] != last_q);

  always_comb begin
    last_d = last_q;
    if (push_done) last_d = avs_writedata[KW-1:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) last_q <= '1;
    else          last_q <= last_d;
  end
`else
  assign push_req = wr_data;
`endif

  assign tick     = frame_cur_q & ~frame_prev_q;
  assign pop_fire = tick & enable_q & ~fifo_empty & ~flush;

  keycode_fifo #(.DEPTH(DEPTH), .KW(KW)) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (push_req),
    .pop       (pop_fire),
    .flush     (flush),
    .din       (avs_writedata[KW-1:0]),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_lvl),
    .push_done (push_done),
    .push_drop (push_drop)
  );

  always_comb begin
    status          = '0;
    status.overflow = overflow_q;
    status.full     = fifo_full;
    status.empty    = fifo_empty;
    status.level    = fifo_lvl[3:0];
  end

  always_comb begin
    enable_d = enable_q;
    if (wr_ctrl) enable_d = avs_writedata[CTRL_EN_BIT];

    // A drop in the same cycle as a clear still leaves overflow set
    overflow_d = overflow_q;
    if (wr_status && avs_writedata[STAT_OVF_BIT]) overflow_d = 1'b0;
    if (push_drop) overflow_d = 1'b1;

    keycode_d   = pop_fire ? fifo_head : keycode_q;
    key_valid_d = pop_fire;

    readdata_d = readdata_q;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:   readdata_d = fifo_empty ? 32'h0 : {{(32-KW){1'b0}}, fifo_head};
        ADDR_STATUS: readdata_d = status;
        ADDR_GAME:   readdata_d = {airtime, 2'b00, outstate, score};
        default:     readdata_d = {31'h0, enable_q};
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cur_q  <= 1'b0;
      frame_prev_q <= 1'b0;
      enable_q     <= 1'b1;
      overflow_q   <= 1'b0;
      keycode_q    <= '0;
      key_valid_q  <= 1'b0;
      readdata_q   <= '0;
    end else begin
      frame_cur_q  <= frame_clk;
      frame_prev_q <= frame_cur_q;
      enable_q     <= enable_d;
      overflow_q   <= overflow_d;
      keycode_q    <= keycode_d;
      key_valid_q  <= key_valid_d;
      readdata_q   <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign keycode      = keycode_q;
  assign key_valid    = key_valid_q;
  assign fifo_level   = fifo_lvl[3:0];

  assign unused_bits = ^{avs_writedata[31:11], avs_writedata[9:8], fifo_lvl[LVL_W-1:4]};

endmodule

// File: tb/tb_keycode_avmm_slave.sv
// Directed bench for keycode_avmm_slave; expectations follow KEY_DEDUP_EN when defined.
module tb_keycode_avmm_slave;
  import keycode_avmm_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        frame_clk = 1'b0;
  logic [15:0] score = '0;
  logic [5:0]  outstate = '0;
  logic [7:0]  airtime = '0;
  logic [7:0]  keycode;
  logic        key_valid;
  logic [3:0]  fifo_level;

  int total = 0;
  int bad = 0;

  keycode_avmm_slave #(.DEPTH(8), .KW(8)) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .frame_clk     (frame_clk),
    .score         (score),
    .outstate      (outstate),
    .airtime       (airtime),
    .keycode       (keycode),
    .key_valid     (key_valid),
    .fifo_level    (fifo_level)
  );

  always #5 Clk = ~Clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge Clk);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    @(negedge Clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    @(negedge Clk);
    avs_address = addr; avs_read = 1'b1;
    @(negedge Clk);
    avs_read = 1'b0;
    data = avs_readdata;
  endtask

  // One frame_clk rise; counts key_valid pulses over a fixed window
  task automatic frame_tick(output int pulses);
    pulses = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      if (key_valid) pulses++;
    end
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  logic [31:0] rd;
  int          np;
  logic [31:0] exp_lvl;

  initial begin
    repeat (3) @(negedge Clk);
    chk_eq("rst_keycode", {24'h0, keycode}, 32'h0);
    chk_eq("rst_key_valid", {31'h0, key_valid}, 32'h0);
    chk_eq("rst_readdata", avs_readdata, 32'h0);
    Reset_n = 1'b1;

    bus_read(ADDR_STATUS, rd);
    chk_eq("status_after_reset", rd, 32'h0000_0100);
    chk_eq("keycode_after_reset", {24'h0, keycode}, 32'h0);

    // Basic release order, one keycode per frame
    bus_write(ADDR_DATA, 32'h1A);
    bus_write(ADDR_DATA, 32'h04);
    bus_read(ADDR_DATA, rd);
    chk_eq("data_peek", rd, 32'h1A);
    bus_read(ADDR_STATUS, rd);
    chk_eq("status_two", rd, 32'h0000_0002);
    frame_tick(np);
    chk_eq("tick1_pulses", np, 1);
    chk_eq("tick1_keycode", {24'h0, keycode}, 32'h1A);
    chk_eq("tick1_level", {28'h0, fifo_level}, 32'd1);
    frame_tick(np);
    chk_eq("tick2_pulses", np, 1);
    chk_eq("tick2_keycode", {24'h0, keycode}, 32'h04);
    chk_eq("tick2_level", {28'h0, fifo_level}, 32'd0);
    frame_tick(np);
    chk_eq("tick3_pulses", np, 0);
    chk_eq("tick3_keycode", {24'h0, keycode}, 32'h04);

    // Overflow: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) bus_write(ADDR_DATA, 32'h10 + i);
    bus_read(ADDR_STATUS, rd);
    chk_eq("status_overflow", rd, 32'h0000_0608);
    bus_write(ADDR_STATUS, 32'h400);
    bus_read(ADDR_STATUS, rd);
    chk_eq("status_ovf_clear", rd, 32'h0000_0208);
    for (int i = 0; i < 8; i++) begin
      frame_tick(np);
      chk_eq($sformatf("ovf_pop%0d", i), {24'h0, keycode}, 32'h10 + i);
    end
    bus_read(ADDR_STATUS, rd);
    chk_eq("status_drained", rd, 32'h0000_0100);

    // Push into a full FIFO in the exact tick cycle
    for (int i = 0; i < 8; i++) bus_write(ADDR_DATA, 32'h20 + i);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    avs_address = ADDR_DATA; avs_writedata = 32'h55; avs_write = 1'b1;
    @(negedge Clk);
    avs_write = 1'b0;
    chk_eq("fullpp_key_valid", {31'h0, key_valid}, 32'h1);
    chk_eq("fullpp_keycode", {24'h0, keycode}, 32'h20);
    chk_eq("fullpp_level", {28'h0, fifo_level}, 32'd8);
    frame_clk = 1'b0;
    bus_read(ADDR_STATUS, rd);
    chk_eq("fullpp_status", rd, 32'h0000_0208);
    for (int i = 0; i < 8; i++) begin
      frame_tick(np);
      chk_eq($sformatf("fullpp_pop%0d", i), {24'h0, keycode}, (i == 7) ? 32'h55 : 32'h21 + i);
    end

    // Game status passthrough, writes ignored
    score = 16'h0123; outstate = 6'h05; airtime = 8'h3C;
    bus_read(ADDR_GAME, rd);
    chk_eq("game_read", rd, 32'h3C05_0123);
    bus_write(ADDR_GAME, 32'hFFFF_FFFF);
    bus_read(ADDR_GAME, rd);
    chk_eq("game_write_ignored", rd, 32'h3C05_0123);
    repeat (3) @(negedge Clk);
    chk_eq("readdata_hold", avs_readdata, 32'h3C05_0123);

    // Flush with entries queued; CTRL=2 also clears enable
    bus_write(ADDR_DATA, 32'h31);
    bus_write(ADDR_DATA, 32'h32);
    bus_write(ADDR_DATA, 32'h33);
    chk_eq("preflush_level", {28'h0, fifo_level}, 32'd3);
    bus_write(ADDR_CTRL, 32'h2);
    chk_eq("flush_level", {28'h0, fifo_level}, 32'd0);
    chk_eq("flush_keycode", {24'h0, keycode}, 32'h55);
    bus_read(ADDR_CTRL, rd);
    chk_eq("ctrl_after_flush", rd, 32'h0);
    bus_read(ADDR_DATA, rd);
    chk_eq("data_empty", rd, 32'h0);

    // Disabled: push accepted, tick ignored
    bus_write(ADDR_DATA, 32'h44);
    frame_tick(np);
    chk_eq("disabled_pulses", np, 0);
    chk_eq("disabled_keycode", {24'h0, keycode}, 32'h55);
    chk_eq("disabled_level", {28'h0, fifo_level}, 32'd1);
    bus_write(ADDR_CTRL, 32'h1);
    frame_tick(np);
    chk_eq("enabled_pulses", np, 1);
    chk_eq("enabled_keycode", {24'h0, keycode}, 32'h44);
    bus_read(ADDR_CTRL, rd);
    chk_eq("ctrl_enabled", rd, 32'h1);

    // Repeated keycode pushes
    bus_write(ADDR_DATA, 32'h07);
    bus_write(ADDR_DATA, 32'h07);
    bus_write(ADDR_DATA, 32'h07);
    bus_write(ADDR_DATA, 32'h00);
`ifdef KEY_DEDUP_EN
    exp_lvl = 32'd2;
`else
    exp_lvl = 32'd4;
`endif
    chk_eq("dedup_level", {28'h0, fifo_level}, exp_lvl);
    bus_read(ADDR_STATUS, rd);
    chk_eq("dedup_status", rd, exp_lvl);

    // Reset in the middle of a push
    @(negedge Clk);
    avs_address = ADDR_DATA; avs_writedata = 32'h99; avs_write = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    chk_eq("midrst_level", {28'h0, fifo_level}, 32'd0);
    chk_eq("midrst_keycode", {24'h0, keycode}, 32'h0);
    chk_eq("midrst_readdata", avs_readdata, 32'h0);
    @(negedge Clk);
    avs_write = 1'b0;
    Reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd);
    chk_eq("midrst_status", rd, 32'h0000_0100);
    bus_read(ADDR_CTRL, rd);
    chk_eq("midrst_ctrl", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
